// File: rtl/feature_map_gather.sv
// Reassembles a channel-interleaved feature stream into per-pixel vectors
// tagged with their (col, row) map position, handed on over valid/ready.
`timescale 1ns/1ps

module feature_map_gather #(
    parameter int FEATURE_WIDTH = 16,
    parameter int NUM_CHANNELS  = 6,
    parameter int MAP_WIDTH     = 24,
    parameter int MAP_HEIGHT    = 24
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_feature_valid,
    input  logic [FEATURE_WIDTH-1:0]                i_feature,
    input  logic                                    i_first,
    output logic                                    o_feature_ready,
    output logic                                    o_features_valid,
    output logic [NUM_CHANNELS*FEATURE_WIDTH-1:0]   o_features,
    output logic [$clog2(MAP_WIDTH)-1:0]            o_col,
    output logic [$clog2(MAP_HEIGHT)-1:0]           o_row,
    output logic                                    o_last,
    input  logic                                    i_features_ready,
    output logic                                    o_sync_err
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int COL_W = $clog2(MAP_WIDTH);
    localparam int ROW_W = $clog2(MAP_HEIGHT);

    localparam logic [CH_W-1:0]  CH_FIRST = '0;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_HEIGHT - 1);

    logic [CH_W-1:0]          ch;
    logic [FEATURE_WIDTH-1:0] slot [NUM_CHANNELS];
    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic                     out_valid;

    logic beat_acc;
    logic drop_beat;
    logic resync;
    logic complete;
    logic store;
    logic [NUM_CHANNELS*FEATURE_WIDTH-1:0] assembled;

    // Only the last channel can stall: it needs the output register free.
    assign o_feature_ready  = !(ch == CH_LAST && out_valid && !i_features_ready);
    assign o_features_valid = out_valid;
    assign o_last           = (o_col == COL_LAST) && (o_row == ROW_LAST);

    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        beat_acc  = i_feature_valid && o_feature_ready;
        drop_beat = 1'b0;
        resync    = 1'b0;
        complete  = 1'b0;
        store     = 1'b0;
        if (beat_acc) begin
            if (ch == CH_FIRST && !i_first) begin
                drop_beat = 1'b1;
            end else if (ch != CH_FIRST && i_first) begin
                resync = 1'b1;
            end else if (ch == CH_LAST) begin
                complete = 1'b1;
            end else begin
                store = 1'b1;
            end
        end
    end

    always_comb begin
        assembled = '0;
        for (int k = 0; k < NUM_CHANNELS - 1; k++) begin
            assembled[k*FEATURE_WIDTH +: FEATURE_WIDTH] = slot[k];
        end
        assembled[(NUM_CHANNELS-1)*FEATURE_WIDTH +: FEATURE_WIDTH] = i_feature;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ch  <= CH_FIRST;
            col <= '0;
            row <= '0;
            // NOTE: the assembly slots are a handful of flops rather than a RAM,
            // so they take the asynchronous reset along with the rest.
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                slot[k] <= '0;
            end
        end else begin
            if (resync) begin
                slot[0] <= i_feature;
                ch      <= CH_W'(1);
            end
            if (store) begin
                slot[ch] <= i_feature;
                ch       <= ch + CH_W'(1);
            end
            if (complete) begin
                ch <= CH_FIRST;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // A newly completed vector takes priority over clearing a consumed one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid  <= 1'b0;
            o_features <= '0;
            o_col      <= '0;
            o_row      <= '0;
        end else if (complete) begin
            out_valid  <= 1'b1;
            o_features <= assembled;
            o_col      <= col;
            o_row      <= row;
        end else if (out_valid && i_features_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sync_err <= 1'b0;
        end else begin
            o_sync_err <= drop_beat || resync;
        end
    end

endmodule

// File: doc/feature_map_gather.md
# feature_map_gather

Receiver side of the serialized feature-map stream. Accepts one 16-bit conv feature per beat, channel-interleaved (ch0..ch5 of one output pixel, then the next pixel), and reassembles each pixel's channels into one NUM_CHANNELS-wide vector. The vector is tagged with its (col, row) map position and handed to the next layer (pooling) over a valid/ready interface. Sits between the feature-map stream output of the conv stage and the pooling input.

## Interface

Parameters:
- FEATURE_WIDTH, 16: bits per feature.
- NUM_CHANNELS, 6: features per vector; equals the conv filter count.
- MAP_WIDTH, 24: columns per output map.
- MAP_HEIGHT, 24: rows per output map.

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_feature_valid  in  1  input beat valid.
- i_feature  in  FEATURE_WIDTH  feature value, two's complement.
- i_first  in  1  marks the ch0 beat of a pixel.
- o_feature_ready  out  1  input beat accepted when valid && ready.
- o_features_valid  out  1  output vector valid.
- o_features  out  NUM_CHANNELS x FEATURE_WIDTH  assembled vector; [k] = channel k.
- o_col  out  $clog2(MAP_WIDTH)  column of the output vector.
- o_row  out  $clog2(MAP_HEIGHT)  row of the output vector.
- o_last  out  1  output vector is the last pixel of the map.
- i_features_ready  in  1  downstream accepts the vector when valid && ready.
- o_sync_err  out  1  one-cycle pulse on a channel misalignment.

## Operation

- Channel counter ch (0..NUM_CHANNELS-1) is the state. It advances on each accepted beat and wraps to 0 after NUM_CHANNELS-1.
- Accepted beat with ch=k, for k < NUM_CHANNELS-1: store into assembly slot k; ch <= k+1.
- Accepted beat with ch=NUM_CHANNELS-1: the vector is complete. Slots 0..N-2 plus this beat load into the output register together with the current position counters. Set out_valid and advance the position. ch <= 0.
- Position: col increments per completed vector. At MAP_WIDTH-1, col wraps to 0 and row increments. At row=MAP_HEIGHT-1 and col=MAP_WIDTH-1, both wrap to 0.
- o_last = (o_col == MAP_WIDTH-1) && (o_row == MAP_HEIGHT-1), taken from the registered position.
- Resync with i_first=1 while ch != 0:
  - Discard the partial vector and pulse o_sync_err.
  - Store the beat as ch0; ch <= 1.
  - Position is not advanced.
- Beat with i_first=0 while ch=0: discard the beat, pulse o_sync_err, ch stays 0.
- Where NUM_CHANNELS=1, every beat must carry i_first.
- Output register:
  - Clears out_valid when it is consumed (valid && i_features_ready) and no new vector is loaded that cycle.
  - Consume and load in the same cycle: the new vector wins; out_valid stays 1.
- Backpressure: o_feature_ready = !(ch == NUM_CHANNELS-1 && out_valid && !i_features_ready). Ready is combinational from state and i_features_ready; there is no path from i_feature_valid.
- Beats for ch < NUM_CHANNELS-1 are always accepted. The assembly slots need no handshake.
- o_features, o_col, o_row and o_last hold stable while out_valid && !i_features_ready.
- No arithmetic is done on feature values; they pass bit-exact.

## Timing

- Reset values (asynchronous assertion):
  - ch=0, col=0, row=0, out_valid=0, assembly slots 0, output register 0.
  - o_features_valid=0, o_features all 0, o_col=0, o_row=0, o_last=0, o_sync_err=0.
  - o_feature_ready=1 (out_valid=0).
- Reset deassertion: the first beat can be accepted on the first i_clk edge after i_rst falls.
- Reset mid-vector: the partial vector is lost and no output is produced for it. The position restarts at (0,0).
- Latency: last channel accepted at edge t -> o_features_valid=1 after edge t, so the vector is visible in cycle t+1.
- Throughput: one vector per NUM_CHANNELS cycles with no stalls. Downstream may stall up to NUM_CHANNELS-1 cycles per vector without stalling the input.
- o_sync_err is registered: it is high in the cycle after the offending beat, for one cycle per event.

## Test plan

- Reset, then 6 beats with values 0x0001..0x0006 (i_first on the first), downstream ready -> one cycle after the 6th beat: o_features_valid=1, o_features[0..5]=0x0001..0x0006, o_col=0, o_row=0, o_last=0, o_sync_err never asserted.
- Stream 576 full vectors (one 24x24 map) -> positions sweep (0,0)..(23,23). o_last=1 only on vector 576 at (23,23). Vector 577 reports (0,0).
- Hold i_features_ready=0 with a vector pending, then send 6 more beats -> first 5 beats accepted. o_feature_ready=0 at the 6th beat until i_features_ready=1. The pending output stays stable. Both vectors delivered in order, with none lost.
- Send 3 beats, then a beat with i_first=1 -> o_sync_err pulses once, no vector is emitted for the 3-beat fragment, and the following vector uses the new beat as ch0 at position (0,0).
- Send a beat with i_first=0 while ch=0 -> beat dropped, o_sync_err pulses, then a clean 6-beat vector produces correct data.
- Assert i_rst after 4 beats of a vector -> all outputs return to reset values immediately. A following clean vector is output at (0,0) with correct data.
